// File: rtl/icevga_pkg.sv
// ============================================================================
// Module      : icevga_pkg
// Description : Shared types and widths for the icevga VRAM host paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icevga_pkg;

   localparam int VRAM_AW = 13;
   localparam int VRAM_DW = 8;
   localparam int HOST_AW = 11;
   localparam int BANK_W  = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SLOT = 3'd1,
      ISSUE     = 3'd2,
      CAPTURE   = 3'd3,
      DRIVE     = 3'd4
   } rdState_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer, parameterizable width and reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/host_readback.sv
// ============================================================================
// Module      : host_readback
// Description : Host VRAM read responder; borrows a free display read slot,
//               captures the byte and drives it until the host ends the cycle.
//               Option macro READBACK_FORCE_STEAL_EN: steal the slot after
//               MAX_WAIT cycles of display contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_readback
   import icevga_pkg::*;
#(
   parameter int MAX_WAIT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [HOST_AW-1:0] hostBusAddr,
   input  logic [BANK_W-1:0]  bank,
   input  logic               nHostRMEM,
   input  logic               nHostVRAMEn,
   input  logic               displayBusy,
   output logic               vramRdSel,
   output logic [VRAM_AW-1:0] vramRdAddr,
   input  logic [VRAM_DW-1:0] vramRdData,
   output logic [VRAM_DW-1:0] hostRdData,
   output logic               hostRdOE,
   output logic               hostBusDir,
   output logic               forcedSteal
);

   logic [1:0]         w_strobeS;
   logic               w_rdSelS;
   logic               w_forceNow;
   logic               r_rdSelSPrev;
   rdState_t           r_state;
   logic               r_vramRdSel;
   logic [VRAM_AW-1:0] r_vramRdAddr;
   logic [VRAM_DW-1:0] r_hostRdData;
   logic               r_hostRdOE;
   logic               r_hostBusDir;
   logic               r_forcedSteal;

   // Both strobes idle high, so "not selected" is the reset value.
   sync2 #(
      .WIDTH     (2),
      .RESET_VAL (2'b11)
   ) u_strobeSync (
      .clk (clk),
      .rst (rst),
      .i_d ({nHostRMEM, nHostVRAMEn}),
      .o_q (w_strobeS)
   );

   assign w_rdSelS = ~|w_strobeS;

`ifdef READBACK_FORCE_STEAL_EN
   localparam int               c_CNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

   logic [c_CNT_W-1:0] r_waitCnt;

   always_ff @(posedge clk) begin
      if (rst || r_state != WAIT_SLOT) begin
         r_waitCnt <= '0;
      end else begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   assign w_forceNow = (r_waitCnt == c_WAIT_LAST);
`else
   // MAX_WAIT only matters with the steal option; this is constant false.
   assign w_forceNow = (MAX_WAIT < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_rdSelSPrev  <= 1'b0;
         r_vramRdSel   <= 1'b0;
         r_vramRdAddr  <= '0;
         r_hostRdData  <= '0;
         r_hostRdOE    <= 1'b0;
         r_hostBusDir  <= 1'b1;
         r_forcedSteal <= 1'b0;
      end else begin
         r_rdSelSPrev  <= w_rdSelS;
         r_vramRdSel   <= 1'b0;
         r_forcedSteal <= 1'b0;
         case (r_state)
            IDLE: begin
               r_hostRdOE   <= 1'b0;
               r_hostBusDir <= 1'b1;
               if (w_rdSelS && !r_rdSelSPrev) begin
                  r_vramRdAddr <= {bank, hostBusAddr};
                  r_state      <= WAIT_SLOT;
               end
            end
            WAIT_SLOT: begin
               if (!w_rdSelS) begin
                  r_state <= IDLE;
               end else if (!displayBusy || w_forceNow) begin
                  r_state       <= ISSUE;
                  r_vramRdSel   <= 1'b1;
                  r_forcedSteal <= displayBusy & w_forceNow;
               end
            end
            ISSUE: begin
               r_state <= w_rdSelS ? CAPTURE : IDLE;
            end
            CAPTURE: begin
               if (!w_rdSelS) begin
                  r_state <= IDLE;
               end else begin
                  r_hostRdData <= vramRdData;
                  r_hostBusDir <= 1'b0;
                  r_state      <= DRIVE;
               end
            end
            DRIVE: begin
               // OE lags direction by one cycle for transceiver turnaround.
               if (!w_rdSelS) begin
                  r_hostRdOE   <= 1'b0;
                  r_hostBusDir <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_hostRdOE <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign vramRdSel   = r_vramRdSel;
   assign vramRdAddr  = r_vramRdAddr;
   assign hostRdData  = r_hostRdData;
   assign hostRdOE    = r_hostRdOE;
   assign hostBusDir  = r_hostBusDir;
   assign forcedSteal = r_forcedSteal;

endmodule

`default_nettype wire

// File: tb/tb_host_readback.sv
// ============================================================================
// Module      : tb_host_readback
// Description : Self-checking bench for host_readback against a window-based
//               transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_readback;
   import icevga_pkg::*;

   localparam int MAX_WAIT_TB = 8;
   localparam int N_MAX       = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hostBusAddr;
   logic [1:0]  bank;
   logic        nHostRMEM;
   logic        nHostVRAMEn;
   logic        displayBusy;
   logic        vramRdSel;
   logic [12:0] vramRdAddr;
   logic [7:0]  vramRdData;
   logic [7:0]  hostRdData;
   logic        hostRdOE;
   logic        hostBusDir;
   logic        forcedSteal;

   host_readback #(.MAX_WAIT(MAX_WAIT_TB)) dut (
      .clk         (clk),
      .rst         (rst),
      .hostBusAddr (hostBusAddr),
      .bank        (bank),
      .nHostRMEM   (nHostRMEM),
      .nHostVRAMEn (nHostVRAMEn),
      .displayBusy (displayBusy),
      .vramRdSel   (vramRdSel),
      .vramRdAddr  (vramRdAddr),
      .vramRdData  (vramRdData),
      .hostRdData  (hostRdData),
      .hostRdOE    (hostRdOE),
      .hostBusDir  (hostBusDir),
      .forcedSteal (forcedSteal)
   );

   always #20 clk = ~clk;

   // VRAM: one-cycle read latency; garbage whenever the host path is not selected.
   logic [7:0] mem [0:8191];
   always @(posedge clk) vramRdData <= vramRdSel ? mem[vramRdAddr] : 8'($urandom);

   int vectors     = 0;
   int miscompares = 0;

   // Per-edge stimulus; obs/expv layout {sel, steal, dir, oe, data[7:0], addr[12:0]}
   logic        rawArr  [N_MAX];
   logic        busyArr [N_MAX];
   logic        rstArr  [N_MAX];
   logic [10:0] addrArr [N_MAX];
   logic [1:0]  bankArr [N_MAX];
   logic [24:0] obs     [N_MAX];
   logic [24:0] expv    [N_MAX];
   int          txSt[$];
   logic [12:0] mAddr = '0;
   logic [7:0]  mData = '0;

   task automatic clear_scenario();
      for (int e = 0; e < N_MAX; e++) begin
         rawArr[e]  = 1'b0;
         busyArr[e] = 1'b0;
         rstArr[e]  = 1'b0;
         addrArr[e] = 11'($urandom);
         bankArr[e] = 2'($urandom);
      end
      txSt.delete();
   endtask

   task automatic add_txn(input int st, input int len, input int hold,
                          input logic [1:0] b, input logic [10:0] a);
      for (int e = st; e < st + len && e < N_MAX; e++) rawArr[e] = 1'b1;
      for (int e = st; e < st + hold && e < N_MAX; e++) begin
         addrArr[e] = a;
         bankArr[e] = b;
      end
      txSt.push_back(st);
   endtask

   // Raw strobe seen at edge st is acted on at st+2; release/abort at L+2.
   task automatic run_model(input int n);
      logic        evLatch [N_MAX];
      logic [12:0] evAddr  [N_MAX];
      logic        evSel   [N_MAX];
      logic        evSteal [N_MAX];
      logic        evCap   [N_MAX];
      logic [7:0]  evData  [N_MAX];
      logic        dirLow  [N_MAX];
      logic        oeHigh  [N_MAX];
      int st, len, rEnd, s;
      logic forced;
      logic [12:0] a;
      for (int e = 0; e < N_MAX; e++) begin
         evLatch[e] = 0; evAddr[e] = '0; evSel[e] = 0; evSteal[e] = 0;
         evCap[e] = 0; evData[e] = '0; dirLow[e] = 0; oeHigh[e] = 0;
      end
      foreach (txSt[i]) begin
         st  = txSt[i];
         len = st + 1;
         while (len < n && rawArr[len]) len++;
         rEnd = st;
         while (rEnd < n && !rstArr[rEnd]) rEnd++;
         if (st + 2 < rEnd) begin
            a = {bankArr[st+2], addrArr[st+2]};
            evLatch[st+2] = 1'b1;
            evAddr[st+2]  = a;
         end else begin
            a = '0;
         end
         s = -1;
         forced = 1'b0;
         for (int e = st + 3; e < len + 2 && e < rEnd; e++) begin
            if (!busyArr[e]) begin
               s = e;
               break;
            end
`ifdef READBACK_FORCE_STEAL_EN
            if (e == st + 2 + MAX_WAIT_TB) begin
               s = e;
               forced = 1'b1;
               break;
            end
`endif
         end
         if (s >= 0) begin
            evSel[s]   = 1'b1;
            evSteal[s] = forced;
            if (len > s) begin
               for (int e = s + 2; e <= len + 1 && e < rEnd; e++) begin
                  dirLow[e] = 1'b1;
                  if (e == s + 2) begin
                     evCap[e]  = 1'b1;
                     evData[e] = mem[a];
                  end
                  if (e >= s + 3) oeHigh[e] = 1'b1;
               end
            end
         end
      end
      for (int e = 0; e < n; e++) begin
         if (rstArr[e]) begin
            mAddr   = '0;
            mData   = '0;
            expv[e] = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 13'h0000};
         end else begin
            if (evLatch[e]) mAddr = evAddr[e];
            if (evCap[e])   mData = evData[e];
            expv[e] = {evSel[e], evSteal[e], !dirLow[e], oeHigh[e], mData, mAddr};
         end
      end
   endtask

   task automatic run_scenario(input int n);
      int k;
      for (int e = 0; e < n; e++) begin
         rst         = rstArr[e];
         hostBusAddr = addrArr[e];
         bank        = bankArr[e];
         displayBusy = busyArr[e];
         if (rawArr[e]) begin
            nHostRMEM   = 1'b0;
            nHostVRAMEn = 1'b0;
         end else begin
            k = $urandom_range(2, 0);
            nHostRMEM   = (k != 1);
            nHostVRAMEn = (k != 0);
         end
         @(posedge clk);
         @(negedge clk);
         obs[e] = {vramRdSel, forcedSteal, hostBusDir, hostRdOE, hostRdData, vramRdAddr};
      end
   endtask

   task automatic test_reset();
      clear_scenario();
      rstArr[0] = 1'b1;
      rstArr[1] = 1'b1;
      run_model(4);
      run_scenario(4);
      for (int e = 0; e < 4; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL reset edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
      end
   endtask

   task automatic test_basic();
      int selCnt = 0;
      mem[13'h0A5] = 8'h5C;
      clear_scenario();
      add_txn(0, 20, 26, 2'd0, 11'h0A5);
      run_model(30);
      run_scenario(30);
      for (int e = 0; e < 30; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL basic edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
         if (obs[e][24]) selCnt++;
      end
      vectors++;
      if ({obs[3][24], obs[3][12:0]} !== {1'b1, 13'h00A5} || selCnt != 1) begin
         miscompares++;
         $display("FAIL basic_issue: sel=%b addr=%h pulses=%0d expected sel=1 addr=00a5 pulses=1",
                  obs[3][24], obs[3][12:0], selCnt);
      end
      vectors++;
      if ({obs[5][21], obs[6][21], obs[6][20:13]} !== {1'b0, 1'b1, 8'h5C}) begin
         miscompares++;
         $display("FAIL basic_drive: oe5=%b oe6=%b data=%h expected 0 1 5c",
                  obs[5][21], obs[6][21], obs[6][20:13]);
      end
      vectors++;
      if ({obs[21][22:21], obs[22][22:21]} !== 4'b0110) begin
         miscompares++;
         $display("FAIL basic_release: dir/oe e21=%b e22=%b expected 01 10",
                  obs[21][22:21], obs[22][22:21]);
      end
   endtask

   task automatic test_bank();
      clear_scenario();
      add_txn(0, 15, 20, 2'd3, 11'h7FF);
      run_model(25);
      run_scenario(25);
      for (int e = 0; e < 25; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL bank edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
      end
      vectors++;
      if ({obs[3][12:0], obs[8][20:13]} !== {13'h1FFF, mem[13'h1FFF]}) begin
         miscompares++;
         $display("FAIL bank_addr: addr=%h data=%h expected 1fff %h",
                  obs[3][12:0], obs[8][20:13], mem[13'h1FFF]);
      end
   endtask

   task automatic test_contention();
      int selCnt = 0, overlap = 0, expIssue, expOverlap;
`ifdef READBACK_FORCE_STEAL_EN
      expIssue   = 2 + MAX_WAIT_TB;
      expOverlap = 1;
`else
      expIssue   = 13;
      expOverlap = 0;
`endif
      clear_scenario();
      for (int e = 3; e < 13; e++) busyArr[e] = 1'b1;
      add_txn(0, 25, 30, 2'($urandom), 11'($urandom));
      run_model(35);
      run_scenario(35);
      for (int e = 0; e < 35; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL contention edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
         if (obs[e][24]) selCnt++;
         if (obs[e][24] && busyArr[e]) overlap++;
      end
      vectors++;
      if (obs[expIssue][24] !== 1'b1 || selCnt != 1 || overlap != expOverlap) begin
         miscompares++;
         $display("FAIL contention_slot: sel@%0d=%b pulses=%0d overlap=%0d expected 1 1 %0d",
                  expIssue, obs[expIssue][24], selCnt, overlap, expOverlap);
      end
   endtask

   task automatic test_abort();
      int bad = 0;
      for (int pass = 0; pass < 2; pass++) begin
         clear_scenario();
         if (pass == 1) for (int e = 0; e < N_MAX; e++) busyArr[e] = 1'b1;
         add_txn(0, 3, 13, 2'($urandom), 11'($urandom));
         run_model(15);
         run_scenario(15);
         for (int e = 0; e < 15; e++) begin
            vectors++;
            if (obs[e] !== expv[e]) begin
               miscompares++;
               $display("FAIL abort%0d edge %0d: got %h expected %h", pass, e, obs[e], expv[e]);
            end
            if (obs[e][21] || !obs[e][22]) bad++;
            if (obs[e][24] && (e >= 5 || pass == 1)) bad++;
         end
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL abort_bus: %0d bad edges, expected 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int selCnt = 0;
      clear_scenario();
      add_txn(0, 12, 13, 2'($urandom), 11'($urandom));
      add_txn(13, 12, 13, 2'($urandom), 11'($urandom));
      add_txn(26, 10, 16, 2'($urandom), 11'($urandom));
      run_model(44);
      run_scenario(44);
      for (int e = 0; e < 44; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL b2b edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
         if (obs[e][24]) selCnt++;
      end
      vectors++;
      if (selCnt != 3) begin
         miscompares++;
         $display("FAIL b2b_count: %0d issues, expected 3", selCnt);
      end
   endtask

   task automatic test_reset_in_drive();
      clear_scenario();
      add_txn(0, 12, 20, 2'($urandom), 11'($urandom));
      rstArr[12] = 1'b1;
      run_model(20);
      run_scenario(20);
      for (int e = 0; e < 20; e++) begin
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL rstdrive edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
      end
      vectors++;
      if ({obs[11][21], obs[12][22:13]} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL rstdrive_outputs: oe11=%b dir/oe/data12=%h expected 1 200",
                  obs[11][21], obs[12][22:13]);
      end
   endtask

   task automatic test_force_steal();
      int selCnt = 0, stealCnt = 0;
      clear_scenario();
      for (int e = 0; e < N_MAX; e++) busyArr[e] = 1'b1;
`ifdef READBACK_FORCE_STEAL_EN
      add_txn(0, 30, 34, 2'($urandom), 11'($urandom));
      run_model(40);
      run_scenario(40);
      for (int e = 0; e < 40; e++) begin
`else
      add_txn(0, 70, 74, 2'($urandom), 11'($urandom));
      run_model(80);
      run_scenario(80);
      for (int e = 0; e < 80; e++) begin
`endif
         vectors++;
         if (obs[e] !== expv[e]) begin
            miscompares++;
            $display("FAIL steal edge %0d: got %h expected %h", e, obs[e], expv[e]);
         end
         if (obs[e][24]) selCnt++;
         if (obs[e][23]) stealCnt++;
      end
      vectors++;
`ifdef READBACK_FORCE_STEAL_EN
      if (obs[10][24:23] !== 2'b11 || selCnt != 1 || stealCnt != 1) begin
         miscompares++;
         $display("FAIL steal_pulse: sel/steal@10=%b issues=%0d steals=%0d expected 11 1 1",
                  obs[10][24:23], selCnt, stealCnt);
      end
`else
      if (selCnt != 0 || stealCnt != 0) begin
         miscompares++;
         $display("FAIL steal_never: issues=%0d steals=%0d expected 0 0", selCnt, stealCnt);
      end
`endif
   endtask

   task automatic test_random();
      int t, n, len, tail, ntx;
      for (int it = 0; it < 20; it++) begin
         clear_scenario();
         for (int e = 0; e < N_MAX; e++) busyArr[e] = ($urandom_range(2, 0) == 0);
         t   = 0;
         ntx = $urandom_range(3, 1);
         for (int k = 0; k < ntx; k++) begin
            len  = $urandom_range(20, 1);
            tail = $urandom_range(4, 1);
            add_txn(t, len, len + tail, 2'($urandom), 11'($urandom));
            t += len + tail;
         end
         n = t + 5;
         run_model(n);
         run_scenario(n);
         for (int e = 0; e < n; e++) begin
            vectors++;
            if (obs[e] !== expv[e]) begin
               miscompares++;
               $display("FAIL random%0d edge %0d: got %h expected %h", it, e, obs[e], expv[e]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      rst         = 1'b1;
      nHostRMEM   = 1'b1;
      nHostVRAMEn = 1'b1;
      displayBusy = 1'b0;
      hostBusAddr = '0;
      bank        = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_bank();
      test_contention();
      test_abort();
      test_back_to_back();
      test_reset_in_drive();
      test_force_steal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
